blinky_lfsr: RTL and testbench

- Free-running Fibonacci LFSR that produces a pseudo-random OUTPUT_WIDTH-bit pattern, used to drive board LEDs.
- Loads a caller-supplied seed during reset.
- Advances one step per enabled clock.
- Maximal-length (period 2^N-1) for every supported width.

---
 rtl/blinky_lfsr.sv | 102 ++++++++++
 tb/tb_blinky_lfsr.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/blinky_lfsr.sv
// Fibonacci LFSR LED pattern generator with async active-low seed load.
// Optional one-cycle period marker on `wrap` when BLINKY_LFSR_WRAP_EN is defined.
module blinky_lfsr #(
  parameter int unsigned             OUTPUT_WIDTH = 4,
  parameter logic [OUTPUT_WIDTH-1:0] TAPS         = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enb,
  input  logic [OUTPUT_WIDTH-1:0] seed,
  output logic [OUTPUT_WIDTH-1:0] out
`ifdef BLINKY_LFSR_WRAP_EN
  , output logic                  wrap
`endif
);

  function automatic logic [31:0] tap(input int unsigned k);
    return 32'h1 << (k - 1);
  endfunction

  // Maximal-length tap positions, tap k = state bit k-1.
  function automatic logic [31:0] table_mask(input int unsigned n);
    case (n)
      2:       return tap(2)  | tap(1);
      3:       return tap(3)  | tap(2);
      4:       return tap(4)  | tap(3);
      5:       return tap(5)  | tap(3);
      6:       return tap(6)  | tap(5);
      7:       return tap(7)  | tap(6);
      8:       return tap(8)  | tap(6)  | tap(5) | tap(4);
      9:       return tap(9)  | tap(5);
      10:      return tap(10) | tap(7);
      11:      return tap(11) | tap(9);
      12:      return tap(12) | tap(6)  | tap(4) | tap(1);
      13:      return tap(13) | tap(4)  | tap(3) | tap(1);
      14:      return tap(14) | tap(5)  | tap(3) | tap(1);
      15:      return tap(15) | tap(14);
      16:      return tap(16) | tap(15) | tap(13) | tap(4);
      17:      return tap(17) | tap(14);
      18:      return tap(18) | tap(11);
      19:      return tap(19) | tap(6)  | tap(2) | tap(1);
      20:      return tap(20) | tap(17);
      21:      return tap(21) | tap(19);
      22:      return tap(22) | tap(21);
      23:      return tap(23) | tap(18);
      24:      return tap(24) | tap(23) | tap(22) | tap(17);
      25:      return tap(25) | tap(22);
      26:      return tap(26) | tap(6)  | tap(2) | tap(1);
      27:      return tap(27) | tap(5)  | tap(2) | tap(1);
      28:      return tap(28) | tap(25);
      29:      return tap(29) | tap(27);
      30:      return tap(30) | tap(6)  | tap(4) | tap(1);
      31:      return tap(31) | tap(28);
      32:      return tap(32) | tap(22) | tap(2) | tap(1);
      default: return '0;
    endcase
  endfunction

  localparam logic [31:0]             TABLE_MASK = table_mask(OUTPUT_WIDTH);
  localparam logic [OUTPUT_WIDTH-1:0] TAP_MASK   =
    (TAPS != '0) ? TAPS : OUTPUT_WIDTH'(TABLE_MASK);
  localparam logic [OUTPUT_WIDTH-1:0] ONE        = OUTPUT_WIDTH'(1);

  if (TAPS == '0 && (OUTPUT_WIDTH < 2 || OUTPUT_WIDTH > 32)) begin : g_width_check
    $error("blinky_lfsr: no built-in tap table for OUTPUT_WIDTH=%0d", OUTPUT_WIDTH);
  end

  logic [OUTPUT_WIDTH-1:0] load_val;
  logic [OUTPUT_WIDTH-1:0] next_state;
  logic                    fb;

  // All-zero seed or state would lock the XOR LFSR, so both map to 0..01.
  always_comb begin
    load_val   = (seed == '0) ? ONE : seed;
    fb         = ^(out & TAP_MASK);
    next_state = (out == '0) ? ONE : {out[OUTPUT_WIDTH-2:0], fb};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      out <= load_val;
    else if (enb)
      out <= next_state;
  end

`ifdef BLINKY_LFSR_WRAP_EN
  logic [OUTPUT_WIDTH-1:0] seed_cap;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      seed_cap <= load_val;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      wrap <= 1'b0;
    else
      wrap <= enb && (next_state == seed_cap);
  end
`endif

endmodule

// File: tb/tb_blinky_lfsr.sv
// Self-checking bench for blinky_lfsr: directed sequences plus randomized enable/reset traffic.
// Checks wrap as well when BLINKY_LFSR_WRAP_EN is defined.
module tb_blinky_lfsr;

  logic       clk = 1'b0;
  logic       rst;
  logic       enb;
  logic [3:0] seed4;
  logic [3:0] out4;
  logic [7:0] out8;
  logic [3:0] outc;
  logic       enb8 = 1'b1;
  logic [7:0] seed8 = 8'h01;
  logic [3:0] seedc = 4'b1000;
`ifdef BLINKY_LFSR_WRAP_EN
  logic       wrap4, wrap8, wrapc;
`endif

  always #5 clk = ~clk;

  blinky_lfsr #(.OUTPUT_WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .enb(enb), .seed(seed4), .out(out4)
`ifdef BLINKY_LFSR_WRAP_EN
    , .wrap(wrap4)
`endif
  );

  blinky_lfsr #(.OUTPUT_WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .enb(enb8), .seed(seed8), .out(out8)
`ifdef BLINKY_LFSR_WRAP_EN
    , .wrap(wrap8)
`endif
  );

  // Tap 1 only: the MSB shifts out, so the state can collapse to zero.
  blinky_lfsr #(.OUTPUT_WIDTH(4), .TAPS(4'b0001)) uc (
    .clk(clk), .rst(rst), .enb(enb), .seed(seedc), .out(outc)
`ifdef BLINKY_LFSR_WRAP_EN
    , .wrap(wrapc)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  int unsigned q4[$] = '{4, 3};
  int unsigned q8[$] = '{8, 6, 5, 4};
  int unsigned qc[$] = '{1};

  int unsigned e4, e8, ec, cap4;
  bit          ewrap;

  logic [3:0] seq4 [16] = '{4'b0100, 4'b1001, 4'b0011, 4'b0110, 4'b1101, 4'b1010,
                            4'b0101, 4'b1011, 4'b0111, 4'b1111, 4'b1110, 4'b1100,
                            4'b1000, 4'b0001, 4'b0010, 4'b0100};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  // Model: state as an integer; shift left by one, feedback is the parity of the tapped bits.
  function automatic int unsigned model_step(input int unsigned s, input int unsigned n,
                                             input int unsigned tp[$]);
    int unsigned fb = 0;
    if (s == 0) return 1;
    foreach (tp[i]) fb = fb ^ ((s >> (tp[i] - 1)) & 1);
    return ((s * 2) + fb) % (1 << n);
  endfunction

  function automatic int unsigned guard(input int unsigned s);
    return (s == 0) ? 1 : s;
  endfunction

  task automatic load_model();
    e4    = guard(seed4);
    cap4  = e4;
    e8    = 1;
    ec    = 8;
    ewrap = 1'b0;
  endtask

  task automatic tick();
    int unsigned n4;
    @(posedge clk);
    if (!rst) begin
      load_model();
    end else begin
      e8 = model_step(e8, 8, q8);
      if (enb) begin
        n4    = model_step(e4, 4, q4);
        ewrap = (n4 == cap4);
        e4    = n4;
        ec    = model_step(ec, 4, qc);
      end else begin
        ewrap = 1'b0;
      end
    end
    #1;
  endtask

  // Called shortly after an edge; reset lands mid-cycle, output checked before the next edge.
  task automatic async_rst(input logic [3:0] s);
    seed4 = s;
    #2;
    rst = 1'b0;
    load_model();
    #1;
    chk("async_load", out4, guard(s));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out4", out4, e4);
      chk("out8", out8, e8);
      chk("outc", outc, ec);
`ifdef BLINKY_LFSR_WRAP_EN
      chk("wrap4", wrap4, ewrap);
`endif
    end
  end

  initial begin
    logic [3:0] held;
    int         distinct;
    bit         seen [256];

    for (int i = 0; i < 15; i++)
      chk("model_pin4", model_step(seq4[i], 4, q4), seq4[i+1]);
    chk("model_pin_lock", model_step(8, 4, qc), 0);
    chk("model_pin_zero", model_step(0, 4, qc), 1);

    rst   = 1'b1;
    enb   = 1'b1;
    seed4 = 4'b0100;
    #2;
    rst = 1'b0;
    load_model();
    chk_en = 1'b1;
    #1;
    chk("reset_out", out4, 4'b0100);
    chk("reset_outc", outc, 4'b1000);

    repeat (10) tick();
    chk("held_in_reset", out4, 4'b0100);

    rst = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("seq4", out4, seq4[i+1]);
`ifdef BLINKY_LFSR_WRAP_EN
      chk("wrap_seq", wrap4, (i == 14));
`endif
    end

    async_rst(4'b0000);
    chk("zero_seed", out4, 4'b0001);
    repeat (2) tick();
    rst = 1'b1;
    tick(); chk("zs_step1", out4, 4'b0010);
    tick(); chk("zs_step2", out4, 4'b0100);
    tick(); chk("zs_step3", out4, 4'b1001);

    repeat (3) tick();
    held = out4;
    enb  = 1'b0;
    repeat (5) tick();
    chk("hold", out4, held);
    enb = 1'b1;
    tick();
    chk("resume", out4, model_step(held, 4, q4));

    async_rst(4'b0100);
    tick();
    rst = 1'b1;
    tick();
    chk("restart", out4, 4'b1001);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        async_rst(($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom_range(0, 15)));
        repeat ($urandom_range(1, 3)) tick();
        rst = 1'b1;
      end else begin
        enb = ($urandom_range(0, 3) != 0);
        tick();
      end
    end

    enb = 1'b1;
    async_rst(4'b0100);
    tick();
    rst      = 1'b1;
    distinct = 0;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    for (int i = 0; i < 255; i++) begin
      if (!seen[out8]) distinct++;
      seen[out8] = 1'b1;
      tick();
    end
    chk("period8_distinct", distinct, 255);
    chk("period8_return", out8, 8'h01);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
